// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and multiply-FSM definitions for alu_pipe.
package alu_pkg;

  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_PASSD = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_ADC   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;

  localparam int unsigned FLG_ZERO  = 0;
  localparam int unsigned FLG_CARRY = 1;
  localparam int unsigned FLG_NEG   = 2;
  localparam int unsigned FLG_OVF   = 3;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle after start.
// done is a level that stays high while idle; product holds the full 2*WIDTH result.
module alu_mul_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(CYCLES + 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CntW-1:0]    cnt_q;
  logic               running_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else if (start) begin
      acc_q     <= '0;
      mcand_q   <= {{WIDTH{1'b0}}, a};
      mplier_q  <= b;
      cnt_q     <= CntW'(CYCLES);
      running_q <= 1'b1;
    end else if (running_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) begin
        running_q <= 1'b0;
      end
    end
  end

  assign done    = !running_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with a registered result stage and sticky carry.
// Define ALU_MUL_EN to add the iterative multiply on opcode 10.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags,
  output logic             carry_q,
  output logic             zero
);

  if (WIDTH < 4 || MUL_CYCLES < 1) begin : g_bad_params
    $error("alu_pipe: WIDTH must be >= 4 and MUL_CYCLES >= 1");
  end

  logic             accept;
  logic             out_free;
  logic             load;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] dec_res;
  logic [WIDTH-1:0] load_res;
  logic [3:0]       dec_flags;
  logic [3:0]       load_flags;
  logic             dec_carry;
  logic             dec_ovf;
  logic             dec_upd;

  assign zero     = (accum == '0);
  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum       = '0;
    dec_res   = accum;
    dec_carry = 1'b0;
    dec_ovf   = 1'b0;
    dec_upd   = 1'b0;
    case (opcode)
      OP_PASSA: dec_res = accum;
      OP_PASSD: dec_res = data;
      OP_ADD, OP_ADC: begin
        sum = {1'b0, accum} + {1'b0, data};
        if (opcode == OP_ADC) begin
          sum = sum + (WIDTH + 1)'(carry_q);
        end
        dec_res   = sum[WIDTH-1:0];
        dec_carry = sum[WIDTH];
        dec_ovf   = (accum[WIDTH-1] == data[WIDTH-1]) && (dec_res[WIDTH-1] != accum[WIDTH-1]);
        dec_upd   = 1'b1;
      end
      OP_SUB: begin
        // Bit WIDTH of the widened difference is the borrow.
        sum       = {1'b0, accum} - {1'b0, data};
        dec_res   = sum[WIDTH-1:0];
        dec_carry = sum[WIDTH];
        dec_ovf   = (accum[WIDTH-1] != data[WIDTH-1]) && (dec_res[WIDTH-1] != accum[WIDTH-1]);
        dec_upd   = 1'b1;
      end
      OP_AND: dec_res = accum & data;
      OP_OR:  dec_res = accum | data;
      OP_XOR: dec_res = accum ^ data;
      OP_SHL: begin
        dec_res   = {accum[WIDTH-2:0], 1'b0};
        dec_carry = accum[WIDTH-1];
        dec_upd   = 1'b1;
      end
      OP_SHR: begin
        dec_res   = {1'b0, accum[WIDTH-1:1]};
        dec_carry = accum[0];
        dec_upd   = 1'b1;
      end
      default: dec_res = accum;
    endcase
  end

  always_comb begin
    dec_flags            = '0;
    dec_flags[FLG_ZERO]  = (dec_res == '0);
    dec_flags[FLG_CARRY] = dec_carry;
    dec_flags[FLG_NEG]   = dec_res[WIDTH-1];
    dec_flags[FLG_OVF]   = dec_ovf;
  end

`ifdef ALU_MUL_EN
  mul_state_e         state_q;
  mul_state_e         state_d;
  logic               mul_start;
  logic               mul_done;
  logic               mul_load;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = accept && (opcode == OP_MUL);
  assign mul_load  = (state_q == StDone) && out_free;
  assign in_ready  = (state_q == StIdle) && out_free;
  assign load      = (accept && !mul_start) || mul_load;

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (accum),
    .b      (data),
    .done   (mul_done),
    .product(mul_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (mul_start) state_d = StBusy;
      StBusy:  if (mul_done) state_d = StDone;
      StDone:  if (out_free) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load_res   = dec_res;
    load_flags = dec_flags;
    if (state_q == StDone) begin
      load_res              = mul_prod[WIDTH-1:0];
      load_flags            = '0;
      load_flags[FLG_ZERO]  = (mul_prod[WIDTH-1:0] == '0);
      load_flags[FLG_NEG]   = mul_prod[WIDTH-1];
      load_flags[FLG_CARRY] = |mul_prod[2*WIDTH-1:WIDTH];
    end
  end
`else
  assign in_ready   = out_free;
  assign load       = accept;
  assign load_res   = dec_res;
  assign load_flags = dec_flags;
`endif

  // A load takes priority over a consume so accept+consume refills without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      flags     <= '0;
      carry_q   <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        alu_out   <= load_res;
        flags     <= load_flags;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && dec_upd) begin
        carry_q <= dec_carry;
      end
    end
  end

endmodule
